// File: rtl/exec_alu_pkg.sv
// Shared instruction-class and operation codes for the execute-stage ALU.
// Shift op codes live beside the arith/logic codes so the issue logic sees one table.
package exec_alu_pkg;

    typedef enum logic [2:0] {
        SHIFT_REG   = 3'b000,
        ARITH_LOGIC = 3'b001,
        MEM_READ    = 3'b010,
        MEM_WRITE   = 3'b011,
        BRANCH      = 3'b100,
        JUMP        = 3'b101
    } opsel_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_HADD = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOT  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_LHG  = 3'b111
    } alu_op_e;

    // 1xx shift codes pass the operand through unshifted.
    typedef enum logic [2:0] {
        SH_SLL = 3'b000,
        SH_SLA = 3'b001,
        SH_SRL = 3'b010,
        SH_SRA = 3'b011
    } shift_op_e;

    localparam int unsigned HALF_W = 16;

endpackage

// File: rtl/exec_shifter.sv
// Iterative 1-bit-per-cycle shifter: loads on start_i, then steps once per cycle until the count drains.
// The step result is exposed combinationally so the caller can capture the final value on the last edge.
module exec_shifter
    import exec_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [SHW-1:0]   cnt_i,
    output logic [WIDTH-1:0] step_res_o,
    output logic             step_carry_o,
    output logic             last_step_o
);

    logic [WIDTH-1:0] operand_q, operand_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    always_comb begin
        step_res_o   = operand_q;
        step_carry_o = 1'b0;
        case (op_q)
            SH_SLL, SH_SLA: begin
                step_res_o   = {operand_q[WIDTH-2:0], 1'b0};
                step_carry_o = operand_q[WIDTH-1];
            end
            SH_SRL: begin
                step_res_o   = {1'b0, operand_q[WIDTH-1:1]};
                step_carry_o = operand_q[0];
            end
            SH_SRA: begin
                step_res_o   = {operand_q[WIDTH-1], operand_q[WIDTH-1:1]};
                step_carry_o = operand_q[0];
            end
            default: ;
        endcase
    end

    assign last_step_o = (cnt_q == SHW'(1));

    always_comb begin
        operand_d = operand_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        if (start_i) begin
            operand_d = operand_i;
            cnt_d     = cnt_i;
            op_d      = op_i;
        end else if (cnt_q != '0) begin
            operand_d = step_res_o;
            cnt_d     = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            operand_q <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
        end else begin
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
        end
    end

endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU: single-cycle arith/logic and load pass-through, multi-cycle shifts with busy stall.
module exec_alu
    import exec_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [2:0]       operation,
    input  logic [2:0]       opselect,
    input  logic [SHW-1:0]   shift_number,
    input  logic             enable_arith,
    input  logic             enable_shift,
    output logic [WIDTH-1:0] aluout,
    output logic             carry,
    output logic             result_valid,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] aluout_q;
    logic             carry_q, valid_q, busy_q;

    logic [WIDTH:0]   add_w, sub_w;
    logic [HALF_W:0]  hadd_w;
    logic [WIDTH-1:0] arith_res;
    logic             arith_carry, arith_hit;

    logic             shift_start;
    logic [WIDTH-1:0] sh_res;
    logic             sh_carry, sh_last;

    always_comb begin
        add_w       = {1'b0, aluin1} + {1'b0, aluin2};
        sub_w       = {1'b0, aluin1} - {1'b0, aluin2};
        hadd_w      = {1'b0, aluin1[HALF_W-1:0]} + {1'b0, aluin2[HALF_W-1:0]};
        arith_res   = '0;
        arith_carry = 1'b0;
        arith_hit   = 1'b0;
        if (opselect == ARITH_LOGIC) begin
            arith_hit = 1'b1;
            case (operation)
                OP_ADD:  begin arith_res = add_w[WIDTH-1:0]; arith_carry = add_w[WIDTH]; end
                OP_HADD: begin
                    arith_res   = {{(WIDTH-HALF_W){hadd_w[HALF_W-1]}}, hadd_w[HALF_W-1:0]};
                    arith_carry = hadd_w[HALF_W];
                end
                OP_SUB:  begin arith_res = sub_w[WIDTH-1:0]; arith_carry = sub_w[WIDTH]; end
                OP_NOT:  arith_res = ~aluin2;
                OP_AND:  arith_res = aluin1 & aluin2;
                OP_OR:   arith_res = aluin1 | aluin2;
                OP_XOR:  arith_res = aluin1 ^ aluin2;
                OP_LHG:  arith_res = {aluin2[HALF_W-1:0], {(WIDTH-HALF_W){1'b0}}};
                default: ;
            endcase
        end else if (opselect == MEM_READ) begin
            arith_hit = 1'b1;
            arith_res = aluin2;
        end
    end

    assign shift_start = (state_q == IDLE) && enable_shift && !enable_arith;

    exec_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .start_i      (shift_start),
        .op_i         (operation),
        .operand_i    (aluin1),
        .cnt_i        (shift_number),
        .step_res_o   (sh_res),
        .step_carry_o (sh_carry),
        .last_step_o  (sh_last)
    );

    // The result is captured on the edge that enters DONE, so result_valid is
    // high during DONE itself and latency is shift_number+1 from the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            aluout_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_arith) begin
                        if (arith_hit) begin
                            aluout_q <= arith_res;
                            carry_q  <= arith_carry;
                            valid_q  <= 1'b1;
                        end
                    end else if (enable_shift) begin
                        busy_q <= 1'b1;
                        if (shift_number == '0) begin
                            aluout_q <= aluin1;
                            carry_q  <= 1'b0;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        aluout_q <= sh_res;
                        carry_q  <= sh_carry;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign aluout       = aluout_q;
    assign carry        = carry_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_exec_alu.sv
// Scoreboard bench for exec_alu: driver pushes expected results, a negedge monitor pops and compares.
module tb_exec_alu;
    import exec_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] aluin1 = '0, aluin2 = '0;
    logic [2:0]  operation = '0, opselect = '0;
    logic [4:0]  shift_number = '0;
    logic        enable_arith = 1'b0, enable_shift = 1'b0;
    logic [31:0] aluout;
    logic        carry, result_valid, busy;

    exec_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .operation    (operation),
        .opselect     (opselect),
        .shift_number (shift_number),
        .enable_arith (enable_arith),
        .enable_shift (enable_shift),
        .aluout       (aluout),
        .carry        (carry),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        logic        c;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0, n_fail = 0;
    int          free_cyc = 0, busy_from = 0, busy_to = -1;
    logic [31:0] hold_r = '0;
    logic        hold_c = 1'b0;
    bit          mon_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_arith(input logic [2:0] osel, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        output bit hit, output logic [31:0] r, output logic c);
        logic [63:0] wide;
        logic [15:0] h16;
        hit = 1'b0; r = '0; c = 1'b0;
        if (osel == ARITH_LOGIC) begin
            hit = 1'b1;
            case (op)
                3'd0: begin wide = 64'(a) + 64'(b); r = wide[31:0]; c = (wide > 64'hFFFF_FFFF); end
                3'd1: begin
                    h16 = a[15:0] + b[15:0];
                    r   = {{16{h16[15]}}, h16};
                    c   = ((int'(a[15:0]) + int'(b[15:0])) > 65535);
                end
                3'd2: begin r = a - b; c = (a < b); end
                3'd3: r = ~b;
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = a ^ b;
                default: r = b << 16;
            endcase
        end else if (osel == MEM_READ) begin
            hit = 1'b1;
            r   = b;
        end
    endfunction

    function automatic void model_shift(input logic [2:0] op, input logic [31:0] a, input int n,
                                        output logic [31:0] r, output logic c);
        r = a; c = 1'b0;
        case (op)
            3'd0, 3'd1: begin r = a << n; if (n > 0) c = a[32-n]; end
            3'd2:       begin r = a >> n; if (n > 0) c = a[n-1]; end
            3'd3:       begin r = 32'($signed(a) >>> n); if (n > 0) c = a[n-1]; end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit ea, input bit es, input logic [2:0] osel, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n,
                         input bit has_exp, input logic [31:0] er, input logic ec);
        int          c;
        bit          hit;
        logic [31:0] r;
        logic        cr;
        exp_t        e;
        c = cyc;
        enable_arith = ea; enable_shift = es; opselect = osel; operation = op;
        aluin1 = a; aluin2 = b; shift_number = 5'(n);
        if (c >= free_cyc) begin
            if (ea) begin
                model_arith(osel, op, a, b, hit, r, cr);
                if (has_exp) begin r = er; cr = ec; end
                if (hit) begin e.r = r; e.c = cr; e.due = c + 1; sb.push_back(e); end
                free_cyc = c + 1;
            end else if (es) begin
                model_shift(op, a, n, r, cr);
                if (has_exp) begin r = er; cr = ec; end
                e.r = r; e.c = cr; e.due = c + 1 + n; sb.push_back(e);
                busy_from = c + 1; busy_to = c + 1 + n; free_cyc = c + 2 + n;
            end
        end
        tick();
        enable_arith = 1'b0; enable_shift = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && cyc <= free_cyc + 1; i++) tick();
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
            if (result_valid) begin
                if (sb.size() == 0) begin
                    chk("valid_spurious", 32'(result_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("aluout", aluout, e.r);
                    chk("carry", 32'(carry), 32'(e.c));
                    chk("valid_cycle", 32'(cyc), 32'(e.due));
                    hold_r = e.r; hold_c = e.c;
                end
            end else begin
                chk("hold_aluout", aluout, hold_r);
                chk("hold_carry", 32'(carry), 32'(hold_c));
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("valid_late", 32'(result_valid), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int          kind, gap, n;
        logic [31:0] a, b;
        logic [2:0]  osel, op;
        bit          ea, es;

        tick(); tick();
        chk("rst_aluout", aluout, 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; free_cyc = cyc; mon_en = 1'b1;
        tick();

        issue(1, 0, ARITH_LOGIC, OP_ADD,  32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 1'b1);
        issue(1, 0, ARITH_LOGIC, OP_HADD, 32'h0000_7FFF, 32'h1, 0, 1, 32'hFFFF_8000, 1'b0);
        issue(1, 0, ARITH_LOGIC, OP_SUB,  32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 1'b1);
        tick();
        issue(0, 1, SHIFT_REG, SH_SRA, 32'h8000_0001, 32'h0, 4, 1, 32'hF800_0000, 1'b0);
        wait_idle();
        issue(0, 1, SHIFT_REG, SH_SRA, 32'h8000_0001, 32'h0, 0, 1, 32'h8000_0001, 1'b0);
        wait_idle();
        issue(1, 0, MEM_READ, 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 1'b0);
        issue(1, 1, ARITH_LOGIC, OP_ADD, 32'd1, 32'd2, 3, 1, 32'd3, 1'b0);
        issue(1, 0, BRANCH, OP_ADD, 32'd9, 32'd9, 0, 0, '0, 1'b0);
        tick();
        issue(0, 1, SHIFT_REG, SH_SLL, 32'h0000_00F1, 32'h0, 6, 1, 32'h0000_3C40, 1'b0);
        tick();
        issue(1, 0, ARITH_LOGIC, OP_ADD, 32'd100, 32'd200, 0, 0, '0, 1'b0);
        wait_idle();

        issue(0, 1, SHIFT_REG, SH_SLL, 32'hFFFF_0000, 32'h0, 10, 0, '0, 1'b0);
        tick();
        rst = 1'b1; sb.delete(); busy_to = cyc; free_cyc = cyc;
        tick();
        rst = 1'b0; hold_r = '0; hold_c = 1'b0;
        chk("midrst_aluout", aluout, 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        issue(1, 0, ARITH_LOGIC, OP_ADD, 32'd40, 32'd2, 0, 1, 32'd42, 1'b0);
        tick();

        for (int i = 0; i < 400; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? 32'h0000_FFFF : $urandom;
            op = 3'($urandom_range(0, 7));
            n = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 12);
            if (kind < 5) begin
                ea = 1; es = ($urandom_range(0, 4) == 0);
                osel = ($urandom_range(0, 4) == 0) ? MEM_READ : ARITH_LOGIC;
            end else if (kind < 9) begin
                ea = 0; es = 1; osel = SHIFT_REG;
            end else begin
                ea = 1; es = 0; osel = BRANCH;
            end
            issue(ea, es, osel, op, a, b, n, 0, '0, 1'b0);
        end

        wait_idle();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
